// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared selection/state types and the ratio decode for clk_sel_ctrl.
package clk_div_pkg;

   typedef logic [1:0] sel_t;

   typedef enum logic [1:0] {IDLE, WAIT_BND, ACK} state_t;

   localparam int MAX_RATIO = 8;

   function automatic int ratio(sel_t s);
      return (s == 2'd0) ? 2 : (s == 2'd1) ? 4 : (s == 2'd2) ? MAX_RATIO : 3;
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse: push-button debounce (all stages high) followed by a rising-edge one-pulse.
module btn_pulse #(
   parameter int DEBOUNCE_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic [DEBOUNCE_LEN-1:0] sh_q, sh_d;
   logic                    deb_q, deb_d;

   always_comb begin
      sh_d  = (sh_q << 1) | DEBOUNCE_LEN'(btn);
      deb_d = &sh_q;
      pulse = &sh_q & ~deb_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q  <= '0;
         deb_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         deb_q <= deb_d;
      end
   end

endmodule

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: clock-enable divider (/2,/4,/8,/3) with boundary-aligned ratio changes via req/ack.
// Define CLK_SEL_BTN_EN to add the debounced btn input that steps the selection.
module clk_sel_ctrl import clk_div_pkg::*; #(
   parameter int   CNT_W   = 5,
   parameter sel_t DEF_SEL = 2'd0
`ifdef CLK_SEL_BTN_EN
   ,parameter int  DEBOUNCE_LEN = 4
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [1:0] req_sel,
   output logic       busy,
   output logic       ack,
   output logic [1:0] cur_sel,
   output logic       div_tick,
   output logic       dclk_level
`ifdef CLK_SEL_BTN_EN
   ,input logic       btn
`endif
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, n;
   sel_t             cur_sel_q, cur_sel_d, pend_q, pend_d, sel_in;
   logic             last, go;

`ifdef CLK_SEL_BTN_EN
   logic pulse;

   btn_pulse #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_btn_pulse (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .pulse (pulse)
   );

   // external req has priority; a coincident button pulse is simply dropped
   assign go     = req | pulse;
   assign sel_in = req ? req_sel : cur_sel_q + 2'd1;
`else
   assign go     = req;
   assign sel_in = req_sel;
`endif

   assign n    = CNT_W'(ratio(cur_sel_q));
   assign last = (cnt_q == n - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cur_sel_q <= DEF_SEL;
         pend_q    <= DEF_SEL;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_sel_q <= cur_sel_d;
         pend_q    <= pend_d;
      end
   end

   always_comb begin
      state_d = (state_q == IDLE)     ? (go ? ((sel_in != cur_sel_q) ? WAIT_BND : ACK) : IDLE) :
                (state_q == WAIT_BND) ? (last ? ACK : WAIT_BND) : IDLE;
      // the switch lands on the last cycle of the old period, so both wrap to 0 together
      cnt_d     = last ? '0 : cnt_q + CNT_W'(1);
      pend_d    = (state_q == IDLE && go) ? sel_in : pend_q;
      cur_sel_d = (state_q == WAIT_BND && last) ? pend_q : cur_sel_q;
   end

   always_comb begin
      busy       = (state_q != IDLE);
      ack        = (state_q == ACK);
      cur_sel    = cur_sel_q;
      div_tick   = last;
      dclk_level = (cnt_q < ((n + CNT_W'(1)) >> 1));
   end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: directed stimulus with an event scoreboard for clk_sel_ctrl.
module tb_clk_sel_ctrl;

   typedef struct packed {
      logic [15:0] rel;
      logic        a;
      logic        t;
      logic [1:0]  c;
      logic        d;
      logic        b;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req = 1'b0;
   logic [1:0] req_sel = 2'd0;
   logic       busy, ack, div_tick, dclk_level;
   logic [1:0] cur_sel;
`ifdef CLK_SEL_BTN_EN
   logic       btn = 1'b0;
`endif
   int         cyc = 0;
   int         t0 = 0;
   int         errors = 0;
   int         checks = 0;
   ev_t        exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   clk_sel_ctrl #(.CNT_W(5), .DEF_SEL(2'd0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_sel    (req_sel),
      .busy       (busy),
      .ack        (ack),
      .cur_sel    (cur_sel),
      .div_tick   (div_tick),
      .dclk_level (dclk_level)
`ifdef CLK_SEL_BTN_EN
      ,.btn       (btn)
`endif
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (rel cycle %0d)", nm, act, expv, cyc - t0);
      end
   endtask

   task automatic ev(int r, bit a, bit t, int c, bit d, bit b);
      ev_t e;
      e = {16'(r), a, t, 2'(c), d, b};
      exp_q.push_back(e);
   endtask

   // monitor: every ack or div_tick cycle is an event and must match the next expected one
   always @(negedge clk) begin : mon
      ev_t got;
      got = {16'(cyc - t0), ack, div_tick, cur_sel, dclk_level, busy};
      if (ack || div_tick) begin
         if (exp_q.size() == 0) chk("unexpected_event", got, 32'd0);
         else chk("event", got, exp_q.pop_front());
      end
   end

   task automatic goto(int k);
      while (cyc - t0 < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_req(int r, int s);
      goto(r);
      req = 1'b1;
      req_sel = 2'(s);
      goto(r + 1);
      req = 1'b0;
   endtask

   task automatic at_dclk(int k, string nm, logic v);
      goto(k);
      chk(nm, dclk_level, v);
   endtask

   task automatic drain(int k);
      goto(k);
      chk("queue_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      #1;
      chk("rst_cur_sel", cur_sel, 2'd0);
      chk("rst_busy_ack_tick_dclk", {busy, ack, div_tick, dclk_level}, 4'b0001);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      t0 = cyc;
   endtask

   initial begin
      #2;
      // reset waveform in /2, then switch to /8 from cnt=0
      reset_dut();
      ev(1, 0, 1, 0, 0, 0);
      ev(3, 0, 1, 0, 0, 0);
      ev(5, 0, 1, 0, 0, 1);
      ev(6, 1, 0, 2, 1, 1);
      ev(13, 0, 1, 2, 0, 0);
      ev(21, 0, 1, 2, 0, 0);
      at_dclk(0, "dclk_r0", 1'b1);
      at_dclk(1, "dclk_r1", 1'b0);
      at_dclk(2, "dclk_r2", 1'b1);
      at_dclk(3, "dclk_r3", 1'b0);
      do_req(4, 2);
      chk("busy_after_accept", busy, 1'b1);
      chk("cur_sel_before_bnd", cur_sel, 2'd0);
      drain(22);

      // same-selection request: ack without touching the counter
      reset_dut();
      ev(1, 0, 1, 0, 0, 1);
      ev(2, 1, 0, 1, 1, 1);
      ev(5, 0, 1, 1, 0, 0);
      ev(7, 1, 0, 1, 1, 1);
      ev(9, 0, 1, 1, 0, 0);
      ev(13, 0, 1, 1, 0, 0);
      do_req(0, 1);
      do_req(6, 1);
      drain(14);

      // /8 -> /3, later requests during WAIT_BND and ACK ignored
      reset_dut();
      ev(1, 0, 1, 0, 0, 1);
      ev(2, 1, 0, 2, 1, 1);
      ev(9, 0, 1, 2, 0, 1);
      ev(10, 1, 0, 3, 1, 1);
      ev(12, 0, 1, 3, 0, 0);
      ev(15, 0, 1, 3, 0, 0);
      ev(18, 0, 1, 3, 0, 0);
      do_req(0, 2);
      do_req(3, 3);
      do_req(5, 0);
      do_req(10, 0);
      chk("cur_sel_div3", cur_sel, 2'd3);
      at_dclk(13, "dclk3_r13", 1'b1);
      at_dclk(14, "dclk3_r14", 1'b1);
      at_dclk(15, "dclk3_r15", 1'b0);
      drain(19);

      // reset in WAIT_BND mid-period discards the pending switch
      reset_dut();
      ev(1, 0, 1, 0, 0, 1);
      ev(2, 1, 0, 2, 1, 1);
      do_req(0, 2);
      do_req(4, 1);
      drain(6);
      chk("busy_in_wait", busy, 1'b1);
      reset_dut();
      ev(1, 0, 1, 0, 0, 0);
      ev(3, 0, 1, 0, 0, 0);
      ev(5, 0, 1, 0, 0, 0);
      drain(6);

`ifdef CLK_SEL_BTN_EN
      // button: bounce ignored, clean press steps 3->0, coincident req wins
      reset_dut();
      ev(1, 0, 1, 0, 0, 1);
      ev(2, 1, 0, 3, 1, 1);
      ev(4, 0, 1, 3, 0, 0);
      ev(7, 0, 1, 3, 0, 0);
      ev(10, 0, 1, 3, 0, 0);
      ev(13, 0, 1, 3, 0, 1);
      ev(14, 1, 0, 0, 1, 1);
      ev(15, 0, 1, 0, 0, 0);
      ev(17, 0, 1, 0, 0, 0);
      ev(19, 0, 1, 0, 0, 0);
      ev(21, 0, 1, 0, 0, 0);
      ev(23, 0, 1, 0, 0, 1);
      ev(24, 1, 0, 2, 1, 1);
      ev(31, 0, 1, 2, 0, 0);
      do_req(0, 3);
      goto(5);  btn = 1'b1;
      goto(7);  btn = 1'b0;
      goto(8);  btn = 1'b1;
      goto(16); btn = 1'b0;
      goto(18); btn = 1'b1;
      goto(22); req = 1'b1; req_sel = 2'd2;
      goto(23); req = 1'b0; btn = 1'b0;
      drain(32);
      chk("btn_final_sel", cur_sel, 2'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
